hazard_control: RTL
===================

Name: hazard_control

Overview:
- Central pipeline sequencer for the 5-stage core: PC, fetchDecode (FD), decodeExecute (DE), executeMemory (EM), memoryWriteback (MW).
- Generates per-register hold/flush controls for load-use hazards, multi-cycle mul/div, data-memory wait, execute-stage branch redirects, writeback-stage traps and serializing instructions (FENCE.I, CSR-serialize).
- Complements the forwarding unit: stalls only where forwarding cannot supply data; EM loads are never forwardable.
- Contains a small FSM, a mul/div watchdog counter and a stall performance counter.

Parameters:
- MULDIV_MAX_CYCLES, 64, watchdog limit for one mul/div operation.
- STALL_COUNT_WIDTH, 32, width of stall performance counter.

Ports:
- clock  input  1  core clock
- reset  input  1  synchronous, active-high reset
- fetchDecodeValid  input  1  FD holds a valid instruction
- fetchDecodeRegister1/fetchDecodeRegister2  input  5 each  FD source registers
- fetchDecodeUses1/fetchDecodeUses2  input  1 each  source actually read
- fetchDecodeSerialize  input  1  FD instruction requires empty pipeline
- decodeExecuteValid  input  1  DE valid
- decodeExecuteIsLoad  input  1  DE instruction is a load
- decodeExecuteIsMulDiv  input  1  DE instruction is mul/div
- decodeExecuteDestinationRegister  input  5  DE rd
- executeMemoryValid  input  1  EM valid
- executeMemoryIsLoad  input  1  EM instruction is a load
- executeMemoryDestinationRegister  input  5  EM rd
- memoryWritebackValid  input  1  MW valid
- branchTaken  input  1  execute-stage redirect (DE instruction resolved taken/mispredicted)
- trapRedirect  input  1  trap/mret committing in MW
- memoryRequest  input  1  EM issuing data-memory access
- memoryReady  input  1  data memory completes access this cycle
- muldivDone  input  1  mul/div result valid this cycle
- muldivStart  output  1  one-cycle start pulse to mul/div unit
- muldivAbort  output  1  cancel in-flight mul/div
- memoryAbort  output  1  cancel in-flight memory access
- pcHold, fetchDecodeHold, decodeExecuteHold, executeMemoryHold  output  1 each  register keeps value
- fetchDecodeFlush, decodeExecuteFlush, executeMemoryFlush, memoryWritebackFlush  output  1 each  register loads bubble
- muldivTimeout  output  1  sticky watchdog error
- stallCount  output  STALL_COUNT_WIDTH  cycles with pcHold=1

Behaviour:
- Reset: state=RUN, all holds/flushes/aborts/muldivStart=0, muldivTimeout=0, stallCount=0, watchdog=0.
- States: RUN, MULDIV, MEMWAIT, DRAIN. Hold/flush outputs are combinational from state and inputs; state, counters and muldivTimeout are registered.
- Load-use hazard (LU): fetchDecodeValid and a used, nonzero source equals rd of a valid load in DE or EM. Response: pcHold, fetchDecodeHold, decodeExecuteFlush. Gives 2 bubbles behind DE load, 1 behind EM load.
- RUN→MEMWAIT: memoryRequest && !memoryReady. In MEMWAIT: pcHold, FD/DE/EM hold, memoryWritebackFlush. Exit to RUN on the memoryReady cycle; release is the same cycle, so zero extra latency.
- RUN→MULDIV: decodeExecuteValid && decodeExecuteIsMulDiv. muldivStart pulses on the entry cycle only. In MULDIV: pcHold, FD/DE hold, executeMemoryFlush.
  - On the muldivDone cycle: release, DE advances, return to RUN.
  - Watchdog counts cycles in MULDIV. On reaching MULDIV_MAX_CYCLES: set muldivTimeout (sticky until reset), pulse muldivAbort, return to RUN; instruction advances with unspecified result.
- RUN→DRAIN: fetchDecodeValid && fetchDecodeSerialize && any of DE/EM/MW valid. In DRAIN: pcHold, fetchDecodeHold, decodeExecuteFlush. Exit to RUN when DE, EM and MW are all invalid; FD advances that cycle.
- branchTaken, in RUN only: fetchDecodeFlush, decodeExecuteFlush. Overrides LU and DRAIN entry.
- trapRedirect, any state, highest priority:
  - Outputs: fetchDecodeFlush, decodeExecuteFlush, executeMemoryFlush; all holds deasserted.
  - If in MULDIV, muldivAbort. If in MEMWAIT, memoryAbort.
  - Next state = RUN; watchdog cleared.
- Priority below trap: MEMWAIT > MULDIV > branchTaken > DRAIN > LU. A stalled younger stage never overrides an older one: a memory stall freezes a mul/div in DE, and MULDIV is entered only once memory is ready.
- Hold and flush are never both asserted on one register; flush wins.
- stallCount increments every cycle pcHold=1 and saturates at all-ones.

Test Plan:
- Load x5 in DE, FD "add x6,x5,x1" → 2 cycles of pcHold/fetchDecodeHold/decodeExecuteFlush, then release. Same sequence with rd=x0 → no stall.
- Mul/div in DE, muldivDone asserted 10 cycles after muldivStart → exactly one start pulse, 10 hold cycles with EM bubbles, RUN after done, stallCount=10.
- memoryRequest with memoryReady low for 3 cycles → MEMWAIT, 3 cycles of MW bubbles, zero-latency release; mul/div waiting in DE starts only after release.
- FENCE.I in FD with EM and MW valid → DRAIN until all invalid (2 cycles), then FD advances; trapRedirect mid-DRAIN → all flushes, RUN.
- muldivDone never arrives, MULDIV_MAX_CYCLES=64 → muldivAbort at cycle 64, muldivTimeout sticky, RUN.
- trapRedirect during MEMWAIT → memoryAbort, three flushes, no holds; reset asserted mid-MULDIV → all outputs 0 next cycle, stallCount=0.

Source files
------------

// File: rtl/hazard_control.sv
// Pipeline sequencer: per-register hold/flush for load-use, mul/div, memory wait,
// branch redirect, trap and serializing instructions, plus watchdog and stall counter.
module hazard_control #(
    parameter int unsigned MULDIV_MAX_CYCLES = 64,
    parameter int unsigned STALL_COUNT_WIDTH = 32
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         fetchDecodeValid,
    input  logic [4:0]                   fetchDecodeRegister1,
    input  logic [4:0]                   fetchDecodeRegister2,
    input  logic                         fetchDecodeUses1,
    input  logic                         fetchDecodeUses2,
    input  logic                         fetchDecodeSerialize,
    input  logic                         decodeExecuteValid,
    input  logic                         decodeExecuteIsLoad,
    input  logic                         decodeExecuteIsMulDiv,
    input  logic [4:0]                   decodeExecuteDestinationRegister,
    input  logic                         executeMemoryValid,
    input  logic                         executeMemoryIsLoad,
    input  logic [4:0]                   executeMemoryDestinationRegister,
    input  logic                         memoryWritebackValid,
    input  logic                         branchTaken,
    input  logic                         trapRedirect,
    input  logic                         memoryRequest,
    input  logic                         memoryReady,
    input  logic                         muldivDone,
    output logic                         muldivStart,
    output logic                         muldivAbort,
    output logic                         memoryAbort,
    output logic                         pcHold,
    output logic                         fetchDecodeHold,
    output logic                         decodeExecuteHold,
    output logic                         executeMemoryHold,
    output logic                         fetchDecodeFlush,
    output logic                         decodeExecuteFlush,
    output logic                         executeMemoryFlush,
    output logic                         memoryWritebackFlush,
    output logic                         muldivTimeout,
    output logic [STALL_COUNT_WIDTH-1:0] stallCount
);

    localparam int unsigned WD_W = $clog2(MULDIV_MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MULDIV  = 2'd1,
        MEMWAIT = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [WD_W-1:0]              wd_q, wd_d;
    logic                         tmo_q, tmo_d;
    logic [STALL_COUNT_WIDTH-1:0] sc_q, sc_d;

    logic lu_hit, pipe_busy, mem_wait;
    logic pc_hold, fd_hold, de_hold, em_hold;
    logic fd_flush, de_flush, em_flush, mw_flush;
    logic md_start, md_abort, mem_abort;

    // Load-use detection: EM loads are never forwardable, so both stages count.
    always_comb begin : hazard_detect
        logic de_load, em_load, hit1, hit2;
        de_load = decodeExecuteValid && decodeExecuteIsLoad;
        em_load = executeMemoryValid && executeMemoryIsLoad;
        hit1 = fetchDecodeUses1 && (fetchDecodeRegister1 != 5'd0) &&
               ((de_load && (fetchDecodeRegister1 == decodeExecuteDestinationRegister)) ||
                (em_load && (fetchDecodeRegister1 == executeMemoryDestinationRegister)));
        hit2 = fetchDecodeUses2 && (fetchDecodeRegister2 != 5'd0) &&
               ((de_load && (fetchDecodeRegister2 == decodeExecuteDestinationRegister)) ||
                (em_load && (fetchDecodeRegister2 == executeMemoryDestinationRegister)));
        lu_hit    = fetchDecodeValid && (hit1 || hit2);
        pipe_busy = decodeExecuteValid || executeMemoryValid || memoryWritebackValid;
        mem_wait  = memoryRequest && !memoryReady;
    end

    always_comb begin : sequencer
        logic dispatch;
        state_d   = state_q;
        wd_d      = '0;
        tmo_d     = tmo_q;
        pc_hold   = 1'b0;
        fd_hold   = 1'b0;
        de_hold   = 1'b0;
        em_hold   = 1'b0;
        fd_flush  = 1'b0;
        de_flush  = 1'b0;
        em_flush  = 1'b0;
        mw_flush  = 1'b0;
        md_start  = 1'b0;
        md_abort  = 1'b0;
        mem_abort = 1'b0;
        dispatch  = 1'b0;

        if (trapRedirect) begin
            fd_flush  = 1'b1;
            de_flush  = 1'b1;
            em_flush  = 1'b1;
            md_abort  = (state_q == MULDIV);
            mem_abort = (state_q == MEMWAIT);
            state_d   = RUN;
        end else begin
            case (state_q)
                RUN: dispatch = 1'b1;
                MULDIV: begin
                    if (muldivDone) begin
                        state_d = RUN;
                    end else if (wd_q >= WD_W'(MULDIV_MAX_CYCLES)) begin
                        md_abort = 1'b1;
                        tmo_d    = 1'b1;
                        state_d  = RUN;
                    end else begin
                        pc_hold  = 1'b1;
                        fd_hold  = 1'b1;
                        de_hold  = 1'b1;
                        em_flush = 1'b1;
                        wd_d     = wd_q + WD_W'(1);
                    end
                end
                // The ready cycle is a normal RUN cycle, so a waiting mul/div starts right away.
                MEMWAIT: begin
                    if (memoryReady) begin
                        dispatch = 1'b1;
                    end else begin
                        pc_hold  = 1'b1;
                        fd_hold  = 1'b1;
                        de_hold  = 1'b1;
                        em_hold  = 1'b1;
                        mw_flush = 1'b1;
                    end
                end
                DRAIN: begin
                    if (mem_wait) begin
                        pc_hold  = 1'b1;
                        fd_hold  = 1'b1;
                        de_hold  = 1'b1;
                        em_hold  = 1'b1;
                        mw_flush = 1'b1;
                        state_d  = MEMWAIT;
                    end else if (pipe_busy) begin
                        pc_hold  = 1'b1;
                        fd_hold  = 1'b1;
                        de_flush = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase

            if (dispatch) begin
                state_d = RUN;
                if (mem_wait) begin
                    pc_hold  = 1'b1;
                    fd_hold  = 1'b1;
                    de_hold  = 1'b1;
                    em_hold  = 1'b1;
                    mw_flush = 1'b1;
                    state_d  = MEMWAIT;
                end else if (decodeExecuteValid && decodeExecuteIsMulDiv) begin
                    md_start = 1'b1;
                    pc_hold  = 1'b1;
                    fd_hold  = 1'b1;
                    de_hold  = 1'b1;
                    em_flush = 1'b1;
                    wd_d     = WD_W'(1);
                    state_d  = MULDIV;
                end else if (branchTaken) begin
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                end else if (fetchDecodeValid && fetchDecodeSerialize && pipe_busy) begin
                    pc_hold  = 1'b1;
                    fd_hold  = 1'b1;
                    de_flush = 1'b1;
                    state_d  = DRAIN;
                end else if (lu_hit) begin
                    pc_hold  = 1'b1;
                    fd_hold  = 1'b1;
                    de_flush = 1'b1;
                end
            end
        end

        sc_d = (pc_hold && (sc_q != '1)) ? sc_q + STALL_COUNT_WIDTH'(1) : sc_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            wd_q    <= '0;
            tmo_q   <= 1'b0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            tmo_q   <= tmo_d;
            sc_q    <= sc_d;
        end
    end

    // Flush wins over hold on the same register; everything is quiet during reset.
    assign pcHold               = pc_hold && !reset;
    assign fetchDecodeHold      = fd_hold && !fd_flush && !reset;
    assign decodeExecuteHold    = de_hold && !de_flush && !reset;
    assign executeMemoryHold    = em_hold && !em_flush && !reset;
    assign fetchDecodeFlush     = fd_flush && !reset;
    assign decodeExecuteFlush   = de_flush && !reset;
    assign executeMemoryFlush   = em_flush && !reset;
    assign memoryWritebackFlush = mw_flush && !reset;
    assign muldivStart          = md_start && !reset;
    assign muldivAbort          = md_abort && !reset;
    assign memoryAbort          = mem_abort && !reset;
    assign muldivTimeout        = tmo_q;
    assign stallCount           = sc_q;

endmodule
